// File: rtl/scan_pkg.sv
// Shared types and helpers for the 4-digit display scan sequencer.
// Holds the FSM state encoding, digit count and nibble helpers.
package scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  function automatic logic [3:0] nibble_sel(input logic [4*NUM_DIGITS-1:0] d,
                                            input logic [IDX_W-1:0] i);
    return d[4*i +: 4];
  endfunction

  // True when digit i is a leading zero: i>0 and it and every higher nibble are 0.
  function automatic logic lead_zero(input logic [4*NUM_DIGITS-1:0] d,
                                     input logic [IDX_W-1:0] i);
    logic z;
    z = (i != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(i) && d[4*k +: 4] != 4'h0) z = 1'b0;
    end
    return z;
  endfunction

endpackage

// File: rtl/digit_scanner_if.sv
// Scan control and display-drive signals between the controller and the scanner.
// master drives run/digits; slave (the scanner) drives the decoder and segment outputs.
interface digit_scanner_if;
  logic        run;
  logic [15:0] digits;
  logic        A;
  logic        B;
  logic        en;
  logic [3:0]  seg_data;
  logic        frame_tick;

  modport master (output run, digits, input A, B, en, seg_data, frame_tick);
  modport slave  (input run, digits, output A, B, en, seg_data, frame_tick);
endinterface

// File: rtl/scan_slot_timer.sv
// Per-slot cycle counter; flags last blank cycle and last slot cycle, wraps to 0 at slot end.
// Flags are combinational off the count register; no backpressure.
module scan_slot_timer #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic blank_done,
  output logic slot_done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign blank_done = (cnt == BLANK_LAST);
  assign slot_done  = (cnt == SLOT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || slot_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/digit_scanner.sv
// 4-digit common-anode scan sequencer: blank-then-show slots, digits snapshotted per frame; all outputs registered, 1-cycle response to run.
// No backpressure. Optional leading-zero suppression under DIGIT_SCANNER_LEADING_ZERO_BLANK_EN.
module digit_scanner
  import scan_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input logic            clk,
  input logic            rst_n,
  digit_scanner_if.slave bus
);

  scan_state_t      state, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [15:0]      snap_q, snap_n;
  logic             snap_ld;
  logic             en_q, en_n;
  logic [3:0]       seg_q, seg_n;
  logic             tick_q, tick_n;
  logic             blank_done, slot_done;
  logic             tmr_clear;

  // Counter is held at 0 while idle or stopping so the first BLANK cycle sees count 0.
  assign tmr_clear = (state == IDLE) || !bus.run;

  scan_slot_timer #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (tmr_clear),
    .blank_done (blank_done),
    .slot_done  (slot_done)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx_q;
    snap_ld = 1'b0;
    tick_n  = 1'b0;
    case (state)
      IDLE: begin
        idx_n = '0;
        if (bus.run) begin
          state_n = BLANK;
          snap_ld = 1'b1;
          tick_n  = 1'b1;
        end
      end
      BLANK: begin
        if (!bus.run) begin
          state_n = IDLE;
          idx_n   = '0;
        end else if (blank_done) begin
          state_n = SHOW;
        end
      end
      SHOW: begin
        if (!bus.run) begin
          state_n = IDLE;
          idx_n   = '0;
        end else if (slot_done) begin
          state_n = BLANK;
          idx_n   = idx_q + 1'b1;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            snap_ld = 1'b1;
            tick_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase

    snap_n = snap_ld ? bus.digits : snap_q;
    seg_n  = (state_n == IDLE) ? 4'h0 : nibble_sel(snap_n, idx_n);
    en_n   = (state_n == SHOW);
`ifdef DIGIT_SCANNER_LEADING_ZERO_BLANK_EN
    if (lead_zero(snap_n, idx_n)) en_n = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx_q  <= '0;
      snap_q <= '0;
      en_q   <= 1'b0;
      seg_q  <= 4'h0;
      tick_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx_q  <= idx_n;
      snap_q <= snap_n;
      en_q   <= en_n;
      seg_q  <= seg_n;
      tick_q <= tick_n;
    end
  end

  assign bus.A          = idx_q[1];
  assign bus.B          = idx_q[0];
  assign bus.en         = en_q;
  assign bus.seg_data   = seg_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Directed bench for digit_scanner with CLK_DIV=8, BLANK_CYCLES=2.
module tb_digit_scanner;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  digit_scanner_if bus ();

  digit_scanner #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ab();
    return {30'd0, bus.A, bus.B};
  endfunction

  initial begin
    int idx;
    int f;
    int exp_en;
    int exp_seg;
    errors = 0;
    checks = 0;
    rst_n      = 1'b0;
    bus.run    = 1'b0;
    bus.digits = 16'h4321;

    // Reset released between edges, block idles while run is low.
    #12 rst_n = 1'b1;
    chk("rst_en", bus.en, 0);
    chk("rst_ab", ab(), 0);
    chk("rst_seg", bus.seg_data, 0);
    chk("rst_tick", bus.frame_tick, 0);
    step();
    step();
    chk("idle_en", bus.en, 0);
    chk("idle_tick", bus.frame_tick, 0);

    // Continuous scan; digits change mid-frame at c=40 (idx 1).
    bus.run = 1'b1;
    step();
    for (int c = 0; c < 115; c++) begin
      idx = (c / 8) % 4;
      f   = c / 32;
      chk("scan_en", bus.en, ((c % 8) >= 2) ? 1 : 0);
      chk("scan_ab", ab(), idx);
      chk("scan_tick", bus.frame_tick, (c % 32 == 0) ? 1 : 0);
      chk("scan_seg", bus.seg_data, (f >= 2) ? idx + 5 : idx + 1);
      if (c == 40) bus.digits = 16'h8765;
      step();
    end

    // Stop during SHOW of idx 2, then restart at idx 0.
    chk("stop_pre_en", bus.en, 1);
    chk("stop_pre_ab", ab(), 2);
    bus.run = 1'b0;
    step();
    chk("stop_en", bus.en, 0);
    chk("stop_ab", ab(), 0);
    chk("stop_seg", bus.seg_data, 0);
    chk("stop_tick", bus.frame_tick, 0);
    step();
    bus.run = 1'b1;
    step();
    chk("restart_ab", ab(), 0);
    chk("restart_tick", bus.frame_tick, 1);
    chk("restart_en", bus.en, 0);
    chk("restart_seg", bus.seg_data, 5);

    // Asynchronous reset mid-SHOW.
    repeat (5) step();
    chk("pre_rst_en", bus.en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_en", bus.en, 0);
    chk("async_rst_ab", ab(), 0);
    chk("async_rst_seg", bus.seg_data, 0);
    chk("async_rst_tick", bus.frame_tick, 0);
    bus.run = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_en", bus.en, 0);
    chk("post_rst_seg", bus.seg_data, 0);
    bus.run = 1'b1;
    step();
    chk("rerun_tick", bus.frame_tick, 1);
    chk("rerun_seg", bus.seg_data, 5);
    chk("rerun_en0", bus.en, 0);
    step();
    chk("rerun_en1", bus.en, 0);
    step();
    chk("rerun_en2", bus.en, 1);

    // run falls on the slot boundary: IDLE wins, no advance, no tick.
    repeat (5) step();
    chk("bnd_pre_en", bus.en, 1);
    chk("bnd_pre_ab", ab(), 0);
    bus.run = 1'b0;
    step();
    chk("bnd_ab", ab(), 0);
    chk("bnd_en", bus.en, 0);
    chk("bnd_tick", bus.frame_tick, 0);
    chk("bnd_seg", bus.seg_data, 0);

    // Leading zeros: frame 0 uses 0042, frame 1 uses 0000.
    bus.digits = 16'h0042;
    bus.run    = 1'b1;
    step();
    for (int c = 0; c < 64; c++) begin
      idx     = (c / 8) % 4;
      f       = c / 32;
      exp_en  = ((c % 8) >= 2) ? 1 : 0;
`ifdef DIGIT_SCANNER_LEADING_ZERO_BLANK_EN
      if (idx > ((f == 0) ? 1 : 0)) exp_en = 0;
`endif
      exp_seg = 0;
      if (f == 0 && idx == 0) exp_seg = 2;
      if (f == 0 && idx == 1) exp_seg = 4;
      chk("lz_en", bus.en, exp_en);
      chk("lz_ab", ab(), idx);
      chk("lz_seg", bus.seg_data, exp_seg);
      if (c == 1) bus.digits = 16'h0000;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
